seg7_mux_bcd: RTL and testbench
===============================

Name: seg7_mux_bcd

Overview:
Parametrised multiplexed 7-segment display driver for N digits. It converts a binary value to BCD with a sequential shift-add-3 (double-dabble) engine instead of combinational division. It adds leading-zero blanking, overflow indication, and a generalised "Err" message mode. It sits between the reaction-time measurement logic and the board's common-anode display, replacing the fixed 4-digit driver.

Parameters:
NUM_DIGITS, 4, number of display digits; legal range 3..8.
VALUE_W, 14, binary input width; constraint VALUE_W <= 3*NUM_DIGITS+3.
REFRESH_W, 16, prescaler width; each digit is lit for 2^REFRESH_W cycles.
ACTIVE_LOW, 1, 1 = seg/an active-low (board default); 0 = both inverted.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
value  in  VALUE_W  binary value to display, sampled on load
load  in  1  single-cycle strobe; captures value when not busy
blank_lz  in  1  1 = blank leading zeros (digit 0 never blanked)
show_error  in  1  1 = show "Err" message, overrides numeric display
seg  out  7  segments {g,f,e,d,c,b,a}, registered
an  out  NUM_DIGITS  digit enables, one-hot (polarity per ACTIVE_LOW), registered
busy  out  1  conversion in progress
overflow  out  1  last converted value >= 10^NUM_DIGITS

Behaviour:
- Reset (sync, clk edge with reset=1): seg all off, an all off, busy=0, overflow=0, display BCD regs=0, digit index=0, prescaler=0, converter to IDLE. Reset mid-conversion aborts it; display shows 0.
- Converter FSM: IDLE -> SHIFT -> COMMIT -> IDLE.
  - IDLE: on load=1, capture value and clear the NUM_DIGITS+1-digit scratch BCD; go to SHIFT; busy=1 from the next cycle.
  - SHIFT: exactly VALUE_W cycles. Each cycle, add 3 to every scratch digit >= 5, then shift left one bit, pulling in the binary MSB.
  - COMMIT: one cycle. Copy the low NUM_DIGITS digits to the display regs and set overflow = (top scratch digit != 0); return to IDLE.
  - busy is high for exactly VALUE_W+1 cycles. load while busy is ignored (no queueing).
  - Display regs change only in COMMIT, so a conversion never shows partial data.
- Refresh: the prescaler increments every cycle. On wrap to 0, the digit index advances 0,1,...,NUM_DIGITS-1,0. No idle or blank slots.
- Output stage: seg/an are registered from the current index, with 1 cycle of latency after an index change. Exactly one an bit is asserted (bit = index), except for blanked digits, where an and seg are both all off.
- Digit content, priority high to low:
  1. show_error: index NUM_DIGITS-1 = E, NUM_DIGITS-2 = r, NUM_DIGITS-3 = r, all others blank.
  2. overflow: every digit shows a dash (segment g only).
  3. Numeric: BCD digit[index]. If blank_lz=1, a digit is blanked when it and all more-significant digits are 0, for index >= 1.
- Encodings, active-low form: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, E=0000110, r=0101111, dash=0111111, off=1111111. ACTIVE_LOW=0 inverts seg and an.
- show_error, blank_lz and overflow are evaluated per refresh cycle, so changes take effect on the next registered output.

Test Plan:
- Bench setup: REFRESH_W=2, defaults otherwise.
1. Reset then idle -> seg=1111111 and an=1111 during reset. After release, digits cycle with an 1110, 1101, 1011, 0111, each held for 4 cycles. All digits show 0 (1000000); busy=0.
2. load with value=1234 -> busy high for exactly 15 cycles. Then digit 3..0 show 1, 2, 3, 4 (1111001, 0100100, 0110000, 0011001); overflow=0.
3. load value=42 with blank_lz=1 -> digits 3 and 2 have an and seg all off; digit 1=0011001, digit 0=0100100. Then load value=0 -> only digit 0 is lit, showing 1000000.
4. load value=16383 -> overflow=1 and all four digits show 0111111. Assert show_error -> digit 3=0000110, digits 2 and 1=0101111, digit 0 blank.
5. load 5678, then pulse load with 9999 during busy -> the second load is ignored and the display shows 5678. Assert reset at cycle 7 of a new conversion -> busy=0 and the display shows 0000 next cycle.
6. NUM_DIGITS=6, VALUE_W=20, load 999999 -> six digits of 9 (0010000); load 1000000 -> overflow=1; an cycles over 6 digits only.

Source files
------------

// File: rtl/seg7_mux_bcd.sv
// Multiplexed N-digit 7-segment driver. A sequential double-dabble engine converts
// the loaded binary value to BCD, and a prescaled scanner drives one digit at a time.
module seg7_mux_bcd #(
    parameter int NUM_DIGITS = 4,
    parameter int VALUE_W    = 14,
    parameter int REFRESH_W  = 16,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic                  show_error,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  busy,
    output logic                  overflow
);
    localparam int BCD_W  = 4 * (NUM_DIGITS + 1);
    localparam int DISP_W = 4 * NUM_DIGITS;
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int CNT_W  = $clog2(VALUE_W + 1);
    localparam int SH_W   = BCD_W + VALUE_W;

    localparam logic [6:0] SEG_OFF   = 7'b1111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_RST   = ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
    localparam logic [NUM_DIGITS-1:0] AN_RST = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT
    } state_t;

    state_t               state_q, state_d;
    logic [VALUE_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]     scratch_q, scratch_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DISP_W-1:0]    disp_q, disp_d;
    logic                 overflow_q, overflow_d;
    logic [REFRESH_W-1:0] presc_q, presc_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [6:0]           seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;

    logic [BCD_W-1:0]     adj;
    logic [SH_W-1:0]      shift_vec;
    logic [NUM_DIGITS:0]  lz_chain;
    logic [3:0]           cur_digit;
    logic [6:0]           seg_al;
    logic                 lit;
    logic [NUM_DIGITS-1:0] an_hot;

    function automatic logic [6:0] decode_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Add-3 correction on every scratch digit before the shift.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS + 1; gi++) begin : g_adj
            assign adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5) ?
                                    scratch_q[4*gi +: 4] + 4'd3 : scratch_q[4*gi +: 4];
        end
    endgenerate

    // Scratch and binary shift as one register pair; the MSB of the scratch falls off.
    assign shift_vec = {adj, bin_q} << 1;

    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        disp_d     = disp_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (load) begin
                    bin_d     = value;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scratch_d = shift_vec[SH_W-1 -: BCD_W];
                bin_d     = shift_vec[VALUE_W-1:0];
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(VALUE_W - 1)) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                disp_d     = scratch_q[DISP_W-1:0];
                overflow_d = |scratch_q[BCD_W-1 -: 4];
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        presc_d = presc_q + REFRESH_W'(1);
        idx_d   = idx_q;
        if (&presc_q) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // lz_chain[i] is set when digit i and every more-significant digit are zero.
    assign lz_chain[NUM_DIGITS] = 1'b1;
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
            assign lz_chain[gi] = lz_chain[gi+1] & (disp_q[4*gi +: 4] == 4'd0);
        end
    endgenerate

    assign cur_digit = disp_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        seg_al = SEG_OFF;
        lit    = 1'b0;
        if (show_error) begin
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                seg_al = SEG_E;
                lit    = 1'b1;
            end else if (idx_q == IDX_W'(NUM_DIGITS - 2) || idx_q == IDX_W'(NUM_DIGITS - 3)) begin
                seg_al = SEG_R;
                lit    = 1'b1;
            end
        end else if (overflow_q) begin
            seg_al = SEG_DASH;
            lit    = 1'b1;
        end else if (!(blank_lz && (idx_q != '0) && lz_chain[idx_q])) begin
            seg_al = decode_digit(cur_digit);
            lit    = 1'b1;
        end
        an_hot = lit ? (NUM_DIGITS'(1) << idx_q) : '0;
        seg_d  = ACTIVE_LOW ? seg_al : ~seg_al;
        an_d   = ACTIVE_LOW ? ~an_hot : an_hot;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bin_q      <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            disp_q     <= '0;
            overflow_q <= 1'b0;
            presc_q    <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_RST;
            an_q       <= AN_RST;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            disp_q     <= disp_d;
            overflow_q <= overflow_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign busy     = (state_q != ST_IDLE);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_seg7_mux_bcd.sv
// Bench for seg7_mux_bcd: a 4-digit and a 6-digit instance checked against a
// decimal-arithmetic display model, with a scan position derived from cycles since reset.
module tb_seg7_mux_bcd;
    localparam int RW = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] value4;
    logic [19:0] value6;
    logic        load4, load6, blank_lz, show_error;
    logic [6:0]  seg4, seg6;
    logic [3:0]  an4;
    logic [5:0]  an6;
    logic        busy4, busy6, ovf4, ovf6;

    int     total = 0;
    int     bad = 0;
    int     cyc;
    bit     sel6 = 1'b0;
    longint disp4 = 0;
    longint disp6 = 0;

    typedef struct {
        int value;
        bit blz;
        bit err;
        bit exp_ovf;
    } vec_t;
    vec_t tbl[6];

    seg7_mux_bcd #(.NUM_DIGITS(4), .VALUE_W(14), .REFRESH_W(RW), .ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .reset(reset), .value(value4), .load(load4), .blank_lz(blank_lz),
        .show_error(show_error), .seg(seg4), .an(an4), .busy(busy4), .overflow(ovf4)
    );

    seg7_mux_bcd #(.NUM_DIGITS(6), .VALUE_W(20), .REFRESH_W(RW), .ACTIVE_LOW(1'b1)) dut6 (
        .clk(clk), .reset(reset), .value(value6), .load(load6), .blank_lz(blank_lz),
        .show_error(show_error), .seg(seg6), .an(an6), .busy(busy6), .overflow(ovf6)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [6:0] dig_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic longint pow10(input int n);
        longint p = 1;
        for (int k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    // Returns {lit, active-low segments} for digit position i of an nd-digit display.
    function automatic logic [7:0] model(input int nd, input longint val, input int i,
                                         input bit blz, input bit err);
        if (err) begin
            if (i == nd - 1) return {1'b1, 7'b0000110};
            if (i == nd - 2 || i == nd - 3) return {1'b1, 7'b0101111};
            return {1'b0, 7'b1111111};
        end
        if (val >= pow10(nd)) return {1'b1, 7'b0111111};
        if (blz && i >= 1 && val < pow10(i)) return {1'b0, 7'b1111111};
        return {1'b1, dig_seg(int'((val / pow10(i)) % 10))};
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic check_cycle();
        int         nd;
        int         idx;
        logic [7:0] m;
        logic [7:0] exp_an, act_an;
        logic [6:0] exp_seg, act_seg;
        longint     v;
        @(negedge clk);
        nd      = sel6 ? 6 : 4;
        v       = sel6 ? disp6 : disp4;
        act_seg = sel6 ? seg6 : seg4;
        act_an  = sel6 ? {2'b11, an6} : {4'hf, an4};
        exp_seg = 7'b1111111;
        exp_an  = 8'hff;
        if (!reset && cyc > 0) begin
            idx     = ((cyc - 1) / 4) % nd;
            m       = model(nd, v, idx, blank_lz, show_error);
            exp_seg = m[6:0];
            if (m[7]) exp_an[idx] = 1'b0;
        end
        total++;
        if (act_seg !== exp_seg || act_an !== exp_an) begin
            bad++;
            $display("FAIL seg_an digits=%0d cyc=%0d got seg=%b an=%b want seg=%b an=%b",
                     nd, cyc, act_seg, act_an, exp_seg, exp_an);
        end
    endtask

    task automatic check_frame(input bit six);
        sel6 = six;
        @(negedge clk);
        repeat ((six ? 6 : 4) * 4) check_cycle();
    endtask

    // Loads v, optionally re-pulses load with extra_v on busy cycle extra_at, checks busy length.
    task automatic do_load(input bit six, input longint v, input int extra_at, input longint extra_v);
        int n;
        int vw;
        int nd;
        logic b;
        vw = six ? 20 : 14;
        nd = six ? 6 : 4;
        @(negedge clk);
        if (six) begin value6 = 20'(v); load6 = 1'b1; end
        else     begin value4 = 14'(v); load4 = 1'b1; end
        @(negedge clk);
        load4 = 1'b0;
        load6 = 1'b0;
        n = 0;
        while (n < 200) begin
            b = six ? busy6 : busy4;
            if (!b) break;
            n++;
            if (n == extra_at) begin
                if (six) begin value6 = 20'(extra_v); load6 = 1'b1; end
                else     begin value4 = 14'(extra_v); load4 = 1'b1; end
            end
            @(negedge clk);
            load4 = 1'b0;
            load6 = 1'b0;
        end
        chk(six ? "busy_len6" : "busy_len4", n, vw + 1);
        if (six) disp6 = v % (longint'(1) << 20);
        else     disp4 = v % (longint'(1) << 14);
        chk(six ? "overflow6" : "overflow4", six ? ovf6 : ovf4,
            ((six ? disp6 : disp4) >= pow10(nd)) ? 1 : 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        tbl[0] = '{1234,  1'b0, 1'b0, 1'b0};
        tbl[1] = '{42,    1'b1, 1'b0, 1'b0};
        tbl[2] = '{0,     1'b1, 1'b0, 1'b0};
        tbl[3] = '{16383, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{16383, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{9999,  1'b1, 1'b0, 1'b0};

        reset = 1'b1; load4 = 1'b0; load6 = 1'b0; value4 = '0; value6 = '0;
        blank_lz = 1'b0; show_error = 1'b0;
        repeat (3) check_cycle();
        chk("reset_busy", busy4, 0);
        chk("reset_ovf", ovf4, 0);
        reset = 1'b0;
        repeat (4 * 4) check_cycle();
        chk("idle_busy", busy4, 0);
        check_frame(1'b1);

        for (int i = 0; i < 6; i++) begin
            blank_lz   = tbl[i].blz;
            show_error = tbl[i].err;
            do_load(1'b0, tbl[i].value, 0, 0);
            chk("tbl_ovf", ovf4, tbl[i].exp_ovf);
            check_frame(1'b0);
        end
        blank_lz   = 1'b0;
        show_error = 1'b0;

        // A load pulse while busy must be dropped, not queued.
        do_load(1'b0, 5678, 4, 9999);
        repeat (3) begin
            @(negedge clk);
            chk("ignored_load_busy", busy4, 0);
        end
        check_frame(1'b0);

        // Reset on the seventh busy cycle aborts the conversion.
        @(negedge clk);
        value4 = 14'd1234;
        load4  = 1'b1;
        @(negedge clk);
        load4 = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy_before_abort", busy4, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy4, 0);
        chk("abort_ovf", ovf4, 0);
        reset = 1'b0;
        disp4 = 0;
        disp6 = 0;
        repeat (4 * 4) check_cycle();
        chk("after_abort_busy", busy4, 0);

        for (int i = 0; i < 10; i++) begin
            v          = int'($urandom_range(0, 16383));
            blank_lz   = 1'($urandom % 2);
            show_error = ($urandom % 8) == 0;
            do_load(1'b0, v, 0, 0);
            check_frame(1'b0);
        end
        blank_lz   = 1'b0;
        show_error = 1'b0;

        do_load(1'b1, 999999, 0, 0);
        check_frame(1'b1);
        do_load(1'b1, 1000000, 0, 0);
        chk("ovf6_1e6", ovf6, 1);
        check_frame(1'b1);
        for (int i = 0; i < 4; i++) begin
            v        = int'($urandom_range(0, 1048575));
            blank_lz = 1'($urandom % 2);
            do_load(1'b1, v, 0, 0);
            check_frame(1'b1);
        end
        show_error = 1'b1;
        @(negedge clk);
        check_frame(1'b1);
        show_error = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
